rps_match: RTL
==============

RPS_MATCH -- requirements
Module: rps_match

Interface
REQ-001 Parameter WINS_TO_MATCH, default 3: round wins one player needs to take the match (1..15).
REQ-002 Parameter SCORE_W, default 4: width of each score counter.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 a_move  input  2  player A move: 2'b11 rock, 2'b10 paper, 2'b00 scissors, 2'b01 illegal.
REQ-006 a_valid  input  1  player A move offered this cycle.
REQ-007 b_move  input  2  player B move, same encoding as a_move.
REQ-008 b_valid  input  1  player B move offered this cycle.
REQ-009 new_match  input  1  clear scores and start a new match.
REQ-010 round_ready  output  1  block is accepting moves.
REQ-011 bad_move  output  1  one-cycle pulse when an illegal move is offered and rejected.
REQ-012 result_valid  output  1  one-cycle pulse marking a judged round.
REQ-013 round_result  output  2  result, qualified by result_valid: 01 A wins, 10 B wins, 11 tie, 00 none.
REQ-014 score_a, score_b  output  SCORE_W each  round wins per player.
REQ-015 match_over  output  1  match decided.
REQ-016 match_winner  output  1  0 = A, 1 = B; valid while match_over.

Function
REQ-017 The FSM SHALL have four states: COLLECT, JUDGE, REPORT, DONE.
REQ-018 COLLECT: round_ready=1; a_move is latched when a_valid=1, the move is legal, and no A move is held; B is handled the same way.
REQ-019 Moves from both players offered in the same cycle SHALL both be latched that cycle.
REQ-020 A further valid from a player whose move is already held SHALL be ignored: first move wins, with no bad_move pulse.
REQ-021 An illegal move (2'b01) SHALL NOT be latched and SHALL raise bad_move in the following cycle, in any state where round_ready=1.
REQ-022 Once both moves are held, the next state SHALL be JUDGE (round_ready=0).
REQ-023 JUDGE SHALL evaluate win/lose/tie combinationally from the held moves and register the result.
REQ-024 REPORT SHALL:
- pulse result_valid for exactly one cycle;
- increment the winner's score in that same cycle (a tie changes no score);
- clear both held moves.
REQ-025 Latency SHALL be 2 cycles from the edge that latches the second move to the edge that asserts result_valid.
REQ-026 After REPORT:
- go to DONE if the updated score equals WINS_TO_MATCH;
- otherwise go to COLLECT.
REQ-027 DONE: round_ready=0, match_over=1, and match_winner holds; moves are ignored.
REQ-028 new_match=1 in any state SHALL on the next edge:
- zero both scores;
- drop any held moves;
- clear match_over;
- enter COLLECT.
REQ-029 new_match SHALL take priority over a round completing in the same cycle; that round's result is discarded and result_valid is not asserted.
REQ-030 Scores SHALL saturate at 2^SCORE_W-1 and never wrap.

Reset
REQ-031 While rst=1:
- state=COLLECT, round_ready=1;
- scores=0, held moves cleared;
- result_valid=0, round_result=00, bad_move=0;
- match_over=0, match_winner=0.
REQ-032 Reset asserted mid-round SHALL discard the round with no result_valid pulse.

Configuration
REQ-033 With macro RPS_LFSR_OPPONENT_EN defined, b_move and b_valid SHALL be ignored and player B SHALL be an 8-bit Fibonacci LFSR with these properties:
- taps 8,6,5,4; seed 8'hA5 on reset;
- advances every cycle;
- B's move is latched in the same cycle as A's move, taken from lfsr[1:0], with 2'b01 mapped to 2'b11.
REQ-034 Without RPS_LFSR_OPPONENT_EN, no LFSR logic SHALL exist and B is driven only by its ports.

Structure
REQ-035 Package rps_pkg SHALL hold:
- move encodings ROCK, PAPER, SCISSORS, ILLEGAL;
- result encodings NONE, A_WIN, B_WIN, TIE;
- the FSM state enum.
REQ-036 Sub-module rps_judge SHALL be a purely combinational move-pair-to-result judge, instantiated once in JUDGE.

Verification
REQ-037 After reset, A=11 and B=00 in the same cycle -> result_valid 2 cycles later with round_result=01, score_a=1, score_b=0.
REQ-038 A=10 at cycle 0, B=11 at cycle 3 -> round_ready held 1 through cycle 3; result_valid at cycle 5 with result=01; a repeat A=00 at cycle 1 is ignored.
REQ-039 Offer A=01 -> bad_move pulses once, nothing latched, round_ready stays 1.
REQ-040 A wins 3 rounds (WINS_TO_MATCH=3) with ties interleaved -> match_over=1, match_winner=0, score_a=3; later moves are ignored; new_match -> scores 0, round_ready=1.
REQ-041 Assert rst one cycle after both moves are latched -> no result_valid pulse, all outputs return to reset values.
REQ-042 With RPS_LFSR_OPPONENT_EN defined, first A move after reset -> B move equals the mapped seed-derived value; b_valid activity has no effect.

Source files
------------

// File: rtl/rps_pkg.sv
// Shared encodings for the rock-paper-scissors match block: moves, round results and FSM states.
package rps_pkg;

    typedef enum logic [1:0] {
        SCISSORS = 2'b00,
        ILLEGAL  = 2'b01,
        PAPER    = 2'b10,
        ROCK     = 2'b11
    } move_t;

    typedef enum logic [1:0] {
        NONE  = 2'b00,
        A_WIN = 2'b01,
        B_WIN = 2'b10,
        TIE   = 2'b11
    } result_t;

    typedef enum logic [1:0] {
        COLLECT = 2'b00,
        JUDGE   = 2'b01,
        REPORT  = 2'b10,
        DONE    = 2'b11
    } state_t;

endpackage

// File: rtl/rps_judge.sv
// Purely combinational judge: maps a pair of legal moves to the round outcome.
module rps_judge
    import rps_pkg::*;
(
    input  move_t   a_move,
    input  move_t   b_move,
    output result_t result
);

    always_comb begin
        result = B_WIN;
        if (a_move == b_move) begin
            result = TIE;
        end else if ((a_move == ROCK     && b_move == SCISSORS) ||
                     (a_move == PAPER    && b_move == ROCK)     ||
                     (a_move == SCISSORS && b_move == PAPER)) begin
            result = A_WIN;
        end
    end

endmodule

// File: rtl/rps_match.sv
// Rock-paper-scissors match controller: collects moves, judges rounds, keeps score to WINS_TO_MATCH.
// Define RPS_LFSR_OPPONENT_EN to replace player B's ports with an internal 8-bit LFSR opponent.
module rps_match
    import rps_pkg::*;
#(
    parameter int WINS_TO_MATCH = 3,
    parameter int SCORE_W       = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         a_move,
    input  logic               a_valid,
    input  logic [1:0]         b_move,
    input  logic               b_valid,
    input  logic               new_match,
    output logic               round_ready,
    output logic               bad_move,
    output logic               result_valid,
    output logic [1:0]         round_result,
    output logic [SCORE_W-1:0] score_a,
    output logic [SCORE_W-1:0] score_b,
    output logic               match_over,
    output logic               match_winner
);

    localparam logic [SCORE_W-1:0] WIN_SCORE = SCORE_W'(WINS_TO_MATCH);
    localparam logic [SCORE_W-1:0] MAX_SCORE = '1;

    state_t     state;
    state_t     state_next;
    move_t      a_held_move;
    move_t      b_held_move;
    logic       a_held;
    logic       b_held;
    result_t    judged;
    logic [1:0] b_src_move;
    logic       b_src_valid;
    logic       a_take;
    logic       b_take;
    logic       a_bad;
    logic       b_bad;

`ifdef RPS_LFSR_OPPONENT_EN
    logic [7:0] lfsr;
    logic       unused_b_ports;

    assign unused_b_ports = ^{b_move, b_valid};

    // Free-running opponent; its move is drawn whenever A's move is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign b_src_move  = (lfsr[1:0] == ILLEGAL) ? ROCK : lfsr[1:0];
    assign b_src_valid = a_take;
    assign b_bad       = 1'b0;
`else
    assign b_src_move  = b_move;
    assign b_src_valid = b_valid;
    assign b_bad       = round_ready && b_valid && !b_held && (b_move == ILLEGAL);
`endif

    assign round_ready = (state == COLLECT);
    assign match_over  = (state == DONE);

    // A player that already holds a move ignores everything, including illegal offers
    assign a_take = round_ready && a_valid && !a_held && (a_move != ILLEGAL);
    assign a_bad  = round_ready && a_valid && !a_held && (a_move == ILLEGAL);
    assign b_take = round_ready && b_src_valid && !b_held && (b_src_move != ILLEGAL);

    rps_judge u_judge (
        .a_move (a_held_move),
        .b_move (b_held_move),
        .result (judged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // REPORT sees the already-updated scores, so the match decision is made there
    always_comb begin
        state_next = state;
        unique case (state)
            COLLECT: if (a_held && b_held) state_next = JUDGE;
            JUDGE:   state_next = REPORT;
            REPORT:  state_next = (score_a == WIN_SCORE || score_b == WIN_SCORE) ? DONE : COLLECT;
            DONE:    state_next = DONE;
            default: state_next = COLLECT;
        endcase
        if (new_match) begin
            state_next = COLLECT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_held       <= 1'b0;
            b_held       <= 1'b0;
            a_held_move  <= SCISSORS;
            b_held_move  <= SCISSORS;
            score_a      <= '0;
            score_b      <= '0;
            result_valid <= 1'b0;
            round_result <= NONE;
            bad_move     <= 1'b0;
            match_winner <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            round_result <= NONE;
            bad_move     <= a_bad || b_bad;
            if (new_match) begin
                a_held       <= 1'b0;
                b_held       <= 1'b0;
                score_a      <= '0;
                score_b      <= '0;
                match_winner <= 1'b0;
            end else begin
                if (a_take) begin
                    a_held      <= 1'b1;
                    a_held_move <= move_t'(a_move);
                end
                if (b_take) begin
                    b_held      <= 1'b1;
                    b_held_move <= move_t'(b_src_move);
                end
                if (state == JUDGE) begin
                    result_valid <= 1'b1;
                    round_result <= judged;
                    if (judged == A_WIN && score_a != MAX_SCORE) begin
                        score_a <= score_a + 1'b1;
                    end
                    if (judged == B_WIN && score_b != MAX_SCORE) begin
                        score_b <= score_b + 1'b1;
                    end
                end
                if (state == REPORT) begin
                    a_held <= 1'b0;
                    b_held <= 1'b0;
                    if (state_next == DONE) begin
                        match_winner <= (score_b == WIN_SCORE);
                    end
                end
            end
        end
    end

endmodule
